video_frame_reader: RTL

- Upstream feeder for the video timing/data stage; sits between the frame-buffer memory read port and the display pipeline, all in video_clk.
- Answers the per-frame read_req with read_req_ack, then fetches the frame linearly in bursts into an internal FIFO.
- Supplies one word per read_en, with the data valid one cycle after read_en.

---
 rtl/video_frame_reader.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/video_frame_reader.sv
// Frame-buffer reader: fetches a frame linearly in bursts into a FIFO
// and hands one word per read_en to the display pipeline.
module video_frame_reader #(
  parameter int          DATA_WIDTH  = 16,
  parameter int          ADDR_WIDTH  = 24,
  parameter int unsigned FRAME_BASE  = 0,
  parameter int          FRAME_WORDS = 921600,
  parameter int          BURST_LEN   = 64,
  parameter int          FIFO_DEPTH  = 512,
  localparam int         LEN_W       = $clog2(BURST_LEN) + 1,
  localparam int         LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  video_clk,
  input  logic                  rst_n,
  input  logic                  read_req,
  output logic                  read_req_ack,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [LEN_W-1:0]      mem_rd_len,
  input  logic                  mem_rd_ack,
  input  logic                  mem_rd_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [LVL_W-1:0]      fifo_level,
  output logic                  underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OW0   = $clog2(FRAME_WORDS + 1);
  localparam int OFF_W = (OW0 > LEN_W) ? OW0 : LEN_W;

  typedef enum logic [2:0] {
    IDLE, DRAIN, FLUSH, CHECK, REQ, DATA, DONE
  } state_t;

  state_t state, next;

  logic [OFF_W-1:0]      offset;
  logic [OFF_W-1:0]      remaining;
  logic [LEN_W-1:0]      cur_len;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      beat_cnt;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic issue;
  logic accept;
  logic flush_go;
  logic beat_last;
  logic space_ok;
  logic wr;
  logic rd;

  assign remaining = OFF_W'(FRAME_WORDS) - offset;
  assign cur_len   = (remaining > OFF_W'(BURST_LEN))
                   ? LEN_W'(BURST_LEN) : LEN_W'(remaining);
  assign space_ok  = (LVL_W'(FIFO_DEPTH) - fifo_level)
                   >= LVL_W'(BURST_LEN);
  assign beat_last = mem_rd_valid
                   && (beat_cnt == len_q - LEN_W'(1));

  assign wr = (state == DATA) && mem_rd_valid
           && (fifo_level != LVL_W'(FIFO_DEPTH));
  assign rd = read_en && (state != FLUSH)
           && (fifo_level != '0);

  assign accept   = issue && mem_rd_ack;
  assign flush_go = (next == FLUSH);

  assign read_req_ack = (state == FLUSH);
  assign mem_rd_req   = issue;
  assign mem_rd_addr  = issue
    ? ADDR_WIDTH'(FRAME_BASE) + ADDR_WIDTH'(offset)
    : '0;
  assign mem_rd_len   = issue ? cur_len : '0;

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  // CHECK issues the command itself so a burst can start without a bubble;
  // an ack always wins over a new read_req so accepted bursts are drained.
  always_comb begin
    next  = state;
    issue = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (read_req) next = FLUSH;
      end
      FLUSH: begin
        next = CHECK;
      end
      CHECK: begin
        if (remaining == '0) begin
          next = read_req ? FLUSH : DONE;
        end else if (space_ok) begin
          issue = 1'b1;
          if (mem_rd_ack)    next = DATA;
          else if (read_req) next = FLUSH;
          else               next = REQ;
        end else if (read_req) begin
          next = FLUSH;
        end
      end
      REQ: begin
        issue = 1'b1;
        if (mem_rd_ack)    next = DATA;
        else if (read_req) next = FLUSH;
      end
      DATA: begin
        if (beat_last)     next = read_req ? FLUSH : CHECK;
        else if (read_req) next = DRAIN;
      end
      DRAIN: begin
        if (beat_last) next = FLUSH;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      offset   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
    end else if (flush_go) begin
      offset   <= '0;
      beat_cnt <= '0;
    end else if (accept) begin
      offset   <= offset + OFF_W'(cur_len);
      len_q    <= cur_len;
      beat_cnt <= '0;
    end else if ((state == DATA || state == DRAIN)
                 && mem_rd_valid) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge video_clk) begin
    if (wr) mem[wptr] <= mem_rd_data;
  end

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      read_data  <= '0;
      underflow  <= 1'b0;
    end else if (flush_go) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      read_data  <= '0;
      underflow  <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + PTR_W'(1);
      if (rd) rptr <= rptr + PTR_W'(1);
      unique case (1'b1)
        (wr && !rd): fifo_level <= fifo_level + LVL_W'(1);
        (rd && !wr): fifo_level <= fifo_level - LVL_W'(1);
        default:     fifo_level <= fifo_level;
      endcase
      read_data <= rd ? mem[rptr] : '0;
      if (read_en && !rd) underflow <= 1'b1;
    end
  end

endmodule
